c7bifu_iq: RTL and testbench

Instruction queue between fetch control and decode. It captures each non-cancelled fetched word together with its PC and fetch-error flag, buffers up to DEPTH entries, and presents the oldest entry to the execution side. It produces the `iq_full` back-pressure that fetch control uses to gate new ICU requests, and it empties on pipeline flush.

---
 rtl/c7bifu_pkg.sv | 15 +
 rtl/c7bifu_iq.sv | 106 ++++++++++
 tb/tb_c7bifu_iq.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/c7bifu_pkg.sv
// Shared IFU definitions: instruction-queue entry layout and sizing constants.
package c7bifu_pkg;

  localparam int IQ_DEPTH_DEF   = 4;
  localparam int IQ_FULL_MARGIN = 1;  // slot kept free for the single in-flight ICU request
  localparam int IQ_IW_DEF      = 32;
  localparam int IQ_AW_DEF      = 32;

  typedef struct packed {
    logic                 err;
    logic [IQ_AW_DEF-1:0] pc;
    logic [IQ_IW_DEF-1:0] inst;
  } iq_entry_t;

endpackage

// File: rtl/c7bifu_iq.sv
// Instruction queue between fetch control and decode: circular buffer of
// {err, pc, inst} entries with flop-derived back-pressure and flush-to-empty.
module c7bifu_iq
  import c7bifu_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH_DEF,
  parameter int IW    = IQ_IW_DEF,
  parameter int AW    = IQ_AW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          icu_data_vld,
  input  logic [IW-1:0] icu_ifu_rdata_ic2,
  input  logic          icu_ifu_err_ic2,
  input  logic [AW-1:0] fetch_pc_ic2,
  input  logic          flush,
  input  logic          stall,
  output logic          iq_full,
  output logic          ifu_exu_valid,
  output logic [IW-1:0] ifu_exu_inst,
  output logic [AW-1:0] ifu_exu_pc,
  output logic          ifu_exu_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] FULL_C  = CW'(DEPTH - IQ_FULL_MARGIN);

  // Same layout as iq_entry_t, sized by this instance's parameters.
  typedef struct packed {
    logic          err;
    logic [AW-1:0] pc;
    logic [IW-1:0] inst;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            push, pop;
  logic [DEPTH-1:0] wr_en;
  entry_t          wr_entry;
  entry_t          head;

  assign push = icu_data_vld & ~flush & (count_q != DEPTH_C);
  assign pop  = (count_q != '0) & ~stall & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign wr_entry = '{err: icu_ifu_err_ic2, pc: fetch_pc_ic2, inst: icu_ifu_rdata_ic2};

  // Storage is deliberately unreset; only the pointers decide what is live.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      assign wr_en[gi] = push && (wr_ptr_q == PW'(gi));
      always_ff @(posedge clk) begin
        if (wr_en[gi]) mem_q[gi] <= wr_entry;
      end
    end
  endgenerate

  assign head          = mem_q[rd_ptr_q];
  assign ifu_exu_valid = (count_q != '0);
  assign ifu_exu_inst  = head.inst;
  assign ifu_exu_pc    = head.pc;
  assign ifu_exu_err   = head.err;
  assign iq_full       = (count_q >= FULL_C);

`ifndef SYNTHESIS
  a_no_overflow : assert property (@(posedge clk) disable iff (reset)
    !(icu_data_vld && !flush && (count_q == DEPTH_C)))
    else $error("c7bifu_iq: push while queue holds DEPTH entries, word dropped");
`endif

endmodule

// File: tb/tb_c7bifu_iq.sv
// Table-driven bench for c7bifu_iq with a queue scoreboard of expected head entries.
module tb_c7bifu_iq;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        icu_data_vld;
  logic [31:0] icu_ifu_rdata_ic2;
  logic        icu_ifu_err_ic2;
  logic [31:0] fetch_pc_ic2;
  logic        flush;
  logic        stall;
  logic        iq_full;
  logic        ifu_exu_valid;
  logic [31:0] ifu_exu_inst;
  logic [31:0] ifu_exu_pc;
  logic        ifu_exu_err;

  always #5 clk = ~clk;

  c7bifu_iq #(.DEPTH(DEPTH), .IW(32), .AW(32)) dut (
    .clk               (clk),
    .reset             (reset),
    .icu_data_vld      (icu_data_vld),
    .icu_ifu_rdata_ic2 (icu_ifu_rdata_ic2),
    .icu_ifu_err_ic2   (icu_ifu_err_ic2),
    .fetch_pc_ic2      (fetch_pc_ic2),
    .flush             (flush),
    .stall             (stall),
    .iq_full           (iq_full),
    .ifu_exu_valid     (ifu_exu_valid),
    .ifu_exu_inst      (ifu_exu_inst),
    .ifu_exu_pc        (ifu_exu_pc),
    .ifu_exu_err       (ifu_exu_err)
  );

  typedef struct {
    logic        rst;
    logic        vld;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        err;
    logic        stall;
    logic        flush;
    logic        exp_v;  // ifu_exu_valid after this edge
    logic        exp_f;  // iq_full after this edge
  } step_t;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        err;
  } ent_t;

  step_t steps[$];
  ent_t  sb[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic add(input logic rst, input logic vld, input logic [31:0] inst,
                     input logic [31:0] pc, input logic err, input logic stl,
                     input logic fl, input logic ev, input logic ef);
    step_t s;
    s.rst = rst; s.vld = vld; s.inst = inst; s.pc = pc; s.err = err;
    s.stall = stl; s.flush = fl; s.exp_v = ev; s.exp_f = ef;
    steps.push_back(s);
  endtask

  initial begin
    reset = 1'b1; icu_data_vld = 1'b0; icu_ifu_rdata_ic2 = '0; icu_ifu_err_ic2 = 1'b0;
    fetch_pc_ic2 = '0; flush = 1'b0; stall = 1'b0;

    // idle after reset
    add(0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // fill with no drain; 4th push accepted at count 3
    add(0, 1, 32'h1111_1111, 32'h1C00_0000, 0, 1, 0, 1, 0);
    add(0, 1, 32'h2222_2222, 32'h1C00_0004, 0, 1, 0, 1, 0);
    add(0, 1, 32'h3333_3333, 32'h1C00_0008, 0, 1, 0, 1, 1);
    add(0, 1, 32'h4444_4444, 32'h1C00_000C, 0, 1, 0, 1, 1);
    // release stall, drain in order
    add(0, 0, 0, 0, 0, 0, 0, 1, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // streaming, 10 back-to-back pushes, one carrying a fetch error
    for (int k = 0; k < 10; k++)
      add(0, 1, 32'hA000_0000 + 32'(k), 32'h1C00_0200 + 32'(4 * k), logic'(k == 4), 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // flush with 3 held plus a simultaneous fetched word
    add(0, 1, 32'hF000_0001, 32'h1C00_0300, 0, 1, 0, 1, 0);
    add(0, 1, 32'hF000_0002, 32'h1C00_0304, 0, 1, 0, 1, 0);
    add(0, 1, 32'hF000_0003, 32'h1C00_0308, 0, 1, 0, 1, 1);
    add(0, 1, 32'hDEAD_BEEF, 32'h1C00_030C, 0, 1, 1, 0, 0);
    add(0, 1, 32'h5555_5555, 32'h1C00_0100, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // simultaneous push and pop at count 3
    add(0, 1, 32'hB000_0001, 32'h1C00_0400, 0, 1, 0, 1, 0);
    add(0, 1, 32'hB000_0002, 32'h1C00_0404, 0, 1, 0, 1, 0);
    add(0, 1, 32'hB000_0003, 32'h1C00_0408, 1, 1, 0, 1, 1);
    add(0, 1, 32'hB000_0004, 32'h1C00_040C, 0, 0, 0, 1, 1);
    add(0, 1, 32'hB000_0005, 32'h1C00_0410, 0, 0, 0, 1, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // reset mid-operation discards held entries and a concurrent word
    add(0, 1, 32'hC000_0001, 32'h1C00_0500, 0, 1, 0, 1, 0);
    add(0, 1, 32'hC000_0002, 32'h1C00_0504, 0, 1, 0, 1, 0);
    add(1, 1, 32'hC000_0003, 32'h1C00_0508, 0, 1, 0, 0, 0);
    add(0, 1, 32'hC000_0004, 32'h1C00_050C, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // reset held for 3 cycles, outputs cleared from the first edge
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("reset%0d valid", i), 32'(ifu_exu_valid), 32'd0);
      check($sformatf("reset%0d full", i), 32'(iq_full), 32'd0);
    end

    foreach (steps[i]) begin
      step_t s;
      int    n;
      s = steps[i];
      @(negedge clk);
      reset = s.rst; icu_data_vld = s.vld; icu_ifu_rdata_ic2 = s.inst;
      fetch_pc_ic2 = s.pc; icu_ifu_err_ic2 = s.err; stall = s.stall; flush = s.flush;

      if (sb.size() > 0) begin
        check($sformatf("s%0d head valid", i), 32'(ifu_exu_valid), 32'd1);
        check($sformatf("s%0d head inst", i), ifu_exu_inst, sb[0].inst);
        check($sformatf("s%0d head pc", i), ifu_exu_pc, sb[0].pc);
        check($sformatf("s%0d head err", i), 32'(ifu_exu_err), 32'(sb[0].err));
      end

      if (s.rst || s.flush) begin
        sb.delete();
      end else begin
        n = sb.size();
        if (n > 0 && !s.stall) void'(sb.pop_front());
        if (s.vld && n < DEPTH) begin
          ent_t e;
          e.inst = s.inst; e.pc = s.pc; e.err = s.err;
          sb.push_back(e);
        end
      end

      @(posedge clk); #1;
      check($sformatf("s%0d valid", i), 32'(ifu_exu_valid), 32'(s.exp_v));
      check($sformatf("s%0d full", i), 32'(iq_full), 32'(s.exp_f));
    end

    @(negedge clk);
    reset = 1'b0; icu_data_vld = 1'b0; stall = 1'b0; flush = 1'b0;
    check("final scoreboard empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
